// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch unit, the load/store unit, mem_arbiter and the memory port.
// The arbiter uses the slave view; whatever drives requests and models memory uses the master view.
interface mem_arbiter_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_error;

    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_error;

    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic        memory_ready;
    logic [31:0] memory_rdata;

    modport slave (
        input  imem_valid, imem_addr,
        input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        input  memory_ready, memory_rdata,
        output imem_ready, imem_rdata, imem_error,
        output dmem_ready, dmem_rdata, dmem_error,
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb
    );

    modport master (
        output imem_valid, imem_addr,
        output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        output memory_ready, memory_rdata,
        input  imem_ready, imem_rdata, imem_error,
        input  dmem_ready, dmem_rdata, dmem_error,
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store pulses onto one memory port: dmem priority with an imem
// anti-starvation limit, one transaction in flight, response timeout and per-port responses.
module mem_arbiter #(
    parameter int unsigned FAIR_LIMIT = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [3:0]  FAIR_MAX = 4'(FAIR_LIMIT);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 32'd1);
    localparam logic        TO_EN    = (TIMEOUT != 32'd0);

    state_e      state_q, state_d;
    logic        cur_dmem_q, cur_dmem_d;
    logic        i_pend_q, i_pend_d;
    logic        d_pend_q, d_pend_d;
    logic [31:0] i_addr_q, i_addr_d;
    logic [31:0] d_addr_q, d_addr_d;
    logic [31:0] d_wdata_q, d_wdata_d;
    logic [3:0]  d_wstrb_q, d_wstrb_d;
    logic [3:0]  fair_q, fair_d;
    logic [15:0] timer_q, timer_d;

    logic        mvalid_q, mvalid_d;
    logic        minstr_q, minstr_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [3:0]  mwstrb_q, mwstrb_d;
    logic        iready_q, iready_d;
    logic [31:0] irdata_q, irdata_d;
    logic        ierror_q, ierror_d;
    logic        dready_q, dready_d;
    logic [31:0] drdata_q, drdata_d;
    logic        derror_q, derror_d;

    logic        busy_s, expire_s, done_s, arb_s, grant_s, pick_i_s;
    logic        i_free_s, d_free_s, i_acc_s, d_acc_s, i_cand_s, d_cand_s;
    logic [31:0] i_addr_sel_s, d_addr_sel_s, d_wdata_sel_s, rsp_data_s;
    logic [3:0]  d_wstrb_sel_s;

    // Completion, capture and arbitration decode. A port whose transaction finishes this
    // cycle is free again, so a pulse arriving in its completion cycle is captured.
    always_comb begin
        busy_s        = (state_q == ST_BUSY);
        expire_s      = TO_EN && busy_s && !bus.memory_ready && (timer_q == TO_LAST);
        done_s        = busy_s && (bus.memory_ready || expire_s);
        i_free_s      = !i_pend_q || (done_s && !cur_dmem_q);
        d_free_s      = !d_pend_q || (done_s && cur_dmem_q);
        i_acc_s       = bus.imem_valid && i_free_s;
        d_acc_s       = bus.dmem_valid && d_free_s;
        i_cand_s      = i_acc_s || (i_pend_q && !(busy_s && !cur_dmem_q));
        d_cand_s      = d_acc_s || (d_pend_q && !(busy_s && cur_dmem_q));
        arb_s         = !busy_s || done_s;
        grant_s       = arb_s && (i_cand_s || d_cand_s);
        pick_i_s      = i_cand_s && (!d_cand_s || (fair_q == FAIR_MAX));
        i_addr_sel_s  = i_acc_s ? bus.imem_addr  : i_addr_q;
        d_addr_sel_s  = d_acc_s ? bus.dmem_addr  : d_addr_q;
        d_wdata_sel_s = d_acc_s ? bus.dmem_wdata : d_wdata_q;
        d_wstrb_sel_s = d_acc_s ? bus.dmem_wstrb : d_wstrb_q;
        rsp_data_s    = bus.memory_ready ? bus.memory_rdata : 32'd0;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a grant always leads to BUSY, a completion without a follow-on grant to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (grant_s) begin
                    state_d = ST_BUSY;
                end else if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, fairness counter, timer and memory-side attributes.
    always_comb begin
        cur_dmem_d = cur_dmem_q;
        i_pend_d   = i_pend_q;
        d_pend_d   = d_pend_q;
        i_addr_d   = i_addr_q;
        d_addr_d   = d_addr_q;
        d_wdata_d  = d_wdata_q;
        d_wstrb_d  = d_wstrb_q;
        fair_d     = fair_q;
        timer_d    = timer_q;
        mvalid_d   = mvalid_q;
        minstr_d   = minstr_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        mwstrb_d   = mwstrb_q;

        if (i_acc_s) begin
            i_pend_d = 1'b1;
            i_addr_d = bus.imem_addr;
        end else if (done_s && !cur_dmem_q) begin
            i_pend_d = 1'b0;
        end else begin
            i_pend_d = i_pend_q;
        end

        if (d_acc_s) begin
            d_pend_d  = 1'b1;
            d_addr_d  = bus.dmem_addr;
            d_wdata_d = bus.dmem_wdata;
            d_wstrb_d = bus.dmem_wstrb;
        end else if (done_s && cur_dmem_q) begin
            d_pend_d = 1'b0;
        end else begin
            d_pend_d = d_pend_q;
        end

        if (grant_s) begin
            if (pick_i_s) begin
                fair_d = 4'd0;
            end else if (i_cand_s) begin
                fair_d = fair_q + 4'd1;
            end else begin
                fair_d = 4'd0;
            end
        end else if (!i_cand_s) begin
            fair_d = 4'd0;
        end else begin
            fair_d = fair_q;
        end

        if (grant_s) begin
            cur_dmem_d = !pick_i_s;
            timer_d    = 16'd0;
            mvalid_d   = 1'b1;
            minstr_d   = pick_i_s;
            maddr_d    = pick_i_s ? i_addr_sel_s : d_addr_sel_s;
            mwdata_d   = pick_i_s ? 32'd0 : d_wdata_sel_s;
            mwstrb_d   = pick_i_s ? 4'd0 : d_wstrb_sel_s;
        end else if (done_s) begin
            timer_d  = 16'd0;
            mvalid_d = 1'b0;
            minstr_d = 1'b0;
            maddr_d  = 32'd0;
            mwdata_d = 32'd0;
            mwstrb_d = 4'd0;
        end else if (busy_s) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Per-port response pulse: data on completion, fault with zero data on timeout.
    always_comb begin
        iready_d = 1'b0;
        irdata_d = 32'd0;
        ierror_d = 1'b0;
        dready_d = 1'b0;
        drdata_d = 32'd0;
        derror_d = 1'b0;
        if (done_s) begin
            if (cur_dmem_q) begin
                dready_d = 1'b1;
                drdata_d = rsp_data_s;
                derror_d = !bus.memory_ready;
            end else begin
                iready_d = 1'b1;
                irdata_d = rsp_data_s;
                ierror_d = !bus.memory_ready;
            end
        end else begin
            iready_d = 1'b0;
            dready_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_dmem_q <= 1'b0;
            i_pend_q   <= 1'b0;
            d_pend_q   <= 1'b0;
            i_addr_q   <= 32'd0;
            d_addr_q   <= 32'd0;
            d_wdata_q  <= 32'd0;
            d_wstrb_q  <= 4'd0;
            fair_q     <= 4'd0;
            timer_q    <= 16'd0;
            mvalid_q   <= 1'b0;
            minstr_q   <= 1'b0;
            maddr_q    <= 32'd0;
            mwdata_q   <= 32'd0;
            mwstrb_q   <= 4'd0;
            iready_q   <= 1'b0;
            irdata_q   <= 32'd0;
            ierror_q   <= 1'b0;
            dready_q   <= 1'b0;
            drdata_q   <= 32'd0;
            derror_q   <= 1'b0;
        end else begin
            cur_dmem_q <= cur_dmem_d;
            i_pend_q   <= i_pend_d;
            d_pend_q   <= d_pend_d;
            i_addr_q   <= i_addr_d;
            d_addr_q   <= d_addr_d;
            d_wdata_q  <= d_wdata_d;
            d_wstrb_q  <= d_wstrb_d;
            fair_q     <= fair_d;
            timer_q    <= timer_d;
            mvalid_q   <= mvalid_d;
            minstr_q   <= minstr_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
            mwstrb_q   <= mwstrb_d;
            iready_q   <= iready_d;
            irdata_q   <= irdata_d;
            ierror_q   <= ierror_d;
            dready_q   <= dready_d;
            drdata_q   <= drdata_d;
            derror_q   <= derror_d;
        end
    end

    assign bus.memory_valid = mvalid_q;
    assign bus.memory_instr = minstr_q;
    assign bus.memory_addr  = maddr_q;
    assign bus.memory_wdata = mwdata_q;
    assign bus.memory_wstrb = mwstrb_q;
    assign bus.imem_ready   = iready_q;
    assign bus.imem_rdata   = irdata_q;
    assign bus.imem_error   = ierror_q;
    assign bus.dmem_ready   = dready_q;
    assign bus.dmem_rdata   = drdata_q;
    assign bus.dmem_error   = derror_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a request-level model
// that tracks pending requests, the in-flight transaction and expected per-cycle outputs.
module tb_mem_arbiter;
    localparam int FAIR_LIMIT = 4;
    localparam int TIMEOUT    = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_arbiter_if bus_if ();

    mem_arbiter #(.FAIR_LIMIT(FAIR_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int obs_dresp = 0;

    // Reference model state: what is waiting, what is on the bus, and what should be seen.
    bit          m_ipend, m_dpend, m_busy, m_cur_d;
    logic [31:0] m_iaddr, m_daddr, m_dwdata;
    logic [3:0]  m_dwstrb;
    int          m_fair, m_timer;
    logic        e_mv, e_mi;
    logic [31:0] e_ma, e_mw;
    logic [3:0]  e_ms;
    logic        e_ir, e_ie, e_dr, e_de;
    logic [31:0] e_ird, e_drd;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit done, pick_i;
        e_ir = 1'b0; e_ie = 1'b0; e_ird = 32'd0;
        e_dr = 1'b0; e_de = 1'b0; e_drd = 32'd0;
        if (reset) begin
            m_ipend = 1'b0; m_dpend = 1'b0; m_busy = 1'b0; m_cur_d = 1'b0;
            m_fair = 0; m_timer = 0;
            e_mv = 1'b0; e_mi = 1'b0; e_ma = 32'd0; e_mw = 32'd0; e_ms = 4'd0;
            return;
        end
        done = m_busy && (bus_if.memory_ready || (TIMEOUT > 0 && m_timer == TIMEOUT - 1));
        if (done) begin
            if (m_cur_d) begin
                e_dr = 1'b1; e_de = !bus_if.memory_ready;
                e_drd = bus_if.memory_ready ? bus_if.memory_rdata : 32'd0;
                m_dpend = 1'b0;
            end else begin
                e_ir = 1'b1; e_ie = !bus_if.memory_ready;
                e_ird = bus_if.memory_ready ? bus_if.memory_rdata : 32'd0;
                m_ipend = 1'b0;
            end
            m_busy = 1'b0;
            e_mv = 1'b0; e_mi = 1'b0; e_ma = 32'd0; e_mw = 32'd0; e_ms = 4'd0;
        end else if (m_busy) begin
            m_timer++;
        end
        if (bus_if.imem_valid && !m_ipend) begin
            m_ipend = 1'b1; m_iaddr = bus_if.imem_addr;
        end
        if (bus_if.dmem_valid && !m_dpend) begin
            m_dpend = 1'b1; m_daddr = bus_if.dmem_addr;
            m_dwdata = bus_if.dmem_wdata; m_dwstrb = bus_if.dmem_wstrb;
        end
        if (!m_busy && (m_ipend || m_dpend)) begin
            pick_i = m_ipend && (!m_dpend || m_fair == FAIR_LIMIT);
            m_busy = 1'b1; m_timer = 0; m_cur_d = !pick_i; e_mv = 1'b1;
            if (pick_i) begin
                e_mi = 1'b1; e_ma = m_iaddr; e_mw = 32'd0; e_ms = 4'd0; m_fair = 0;
            end else begin
                e_mi = 1'b0; e_ma = m_daddr; e_mw = m_dwdata; e_ms = m_dwstrb;
                m_fair = m_ipend ? m_fair + 1 : 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        if (bus_if.dmem_ready === 1'b1) obs_dresp++;
        check_eq("mem", {58'd0, bus_if.memory_valid, bus_if.memory_instr, bus_if.memory_addr,
                         bus_if.memory_wdata, bus_if.memory_wstrb},
                        {58'd0, e_mv, e_mi, e_ma, e_mw, e_ms});
        check_eq("imem", {94'd0, bus_if.imem_ready, bus_if.imem_error, bus_if.imem_rdata},
                         {94'd0, e_ir, e_ie, e_ird});
        check_eq("dmem", {94'd0, bus_if.dmem_ready, bus_if.dmem_error, bus_if.dmem_rdata},
                         {94'd0, e_dr, e_de, e_drd});
        check_eq("excl", 128'(bus_if.imem_ready & bus_if.dmem_ready), 128'd0);
    endtask

    task automatic quiet();
        bus_if.imem_valid   = 1'b0;
        bus_if.dmem_valid   = 1'b0;
        bus_if.memory_ready = 1'b0;
        bus_if.memory_rdata = $urandom;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && e_mv; k++) begin
            bus_if.memory_ready = 1'b1;
            bus_if.memory_rdata = $urandom;
            tick();
        end
        quiet();
        tick();
    endtask

    initial begin
        int nd, cnt, d0;
        reset = 1'b1;
        bus_if.imem_addr  = 32'd0;
        bus_if.dmem_addr  = 32'd0;
        bus_if.dmem_wdata = 32'd0;
        bus_if.dmem_wstrb = 4'd0;
        quiet();
        tick();
        tick();
        check_eq("rst_out", {125'd0, bus_if.memory_valid, bus_if.imem_ready, bus_if.dmem_ready}, 128'd0);
        reset = 1'b0;

        // Single fetch.
        bus_if.imem_valid = 1'b1; bus_if.imem_addr = 32'h0000_0100;
        tick();
        quiet();
        check_eq("fetch_issue", 128'({bus_if.memory_valid, bus_if.memory_instr, bus_if.memory_addr}),
                                128'({1'b1, 1'b1, 32'h0000_0100}));
        tick();
        bus_if.memory_ready = 1'b1; bus_if.memory_rdata = 32'hCAFE_0013;
        tick();
        quiet();
        check_eq("fetch_resp", 128'({bus_if.imem_ready, bus_if.imem_error, bus_if.imem_rdata, bus_if.memory_valid}),
                               128'({1'b1, 1'b0, 32'hCAFE_0013, 1'b0}));
        tick();

        // Simultaneous fetch and store: store first, fetch follows back to back.
        bus_if.imem_valid = 1'b1; bus_if.imem_addr = 32'h0000_0200;
        bus_if.dmem_valid = 1'b1; bus_if.dmem_addr = 32'h0000_0300;
        bus_if.dmem_wdata = 32'h1234_5678; bus_if.dmem_wstrb = 4'hF;
        tick();
        quiet();
        check_eq("both_first", 128'({bus_if.memory_instr, bus_if.memory_addr, bus_if.memory_wstrb}),
                               128'({1'b0, 32'h0000_0300, 4'hF}));
        bus_if.memory_ready = 1'b1;
        tick();
        quiet();
        check_eq("both_second", 128'({bus_if.dmem_ready, bus_if.memory_valid, bus_if.memory_instr, bus_if.memory_addr}),
                                128'({1'b1, 1'b1, 1'b1, 32'h0000_0200}));
        bus_if.memory_ready = 1'b1;
        tick();
        quiet();
        check_eq("both_done", 128'({bus_if.imem_ready, bus_if.dmem_ready, bus_if.memory_valid}), 128'({1'b1, 1'b0, 1'b0}));
        tick();

        // Fairness: dmem re-requests in every completion cycle while a fetch waits.
        nd = 0;
        bus_if.imem_valid = 1'b1; bus_if.imem_addr = 32'h0000_0500;
        bus_if.dmem_valid = 1'b1; bus_if.dmem_addr = 32'h0000_0600; bus_if.dmem_wstrb = 4'd0;
        tick();
        quiet();
        for (int k = 0; k < 8; k++) begin
            if (!(bus_if.memory_valid === 1'b1 && bus_if.memory_instr === 1'b0)) break;
            nd++;
            bus_if.memory_ready = 1'b1;
            bus_if.dmem_valid   = 1'b1;
            bus_if.dmem_addr    = 32'h0000_0600 + 32'(k);
            tick();
            quiet();
        end
        check_eq("fair_dgrants", 128'(nd), 128'd4);
        check_eq("fair_igrant", 128'({bus_if.memory_valid, bus_if.memory_instr}), 128'({1'b1, 1'b1}));
        check_eq("fair_cnt", 128'(dut.fair_q), 128'd0);
        drain();

        // Timeout on a load with memory never answering.
        bus_if.dmem_valid = 1'b1; bus_if.dmem_addr = 32'h0000_0700; bus_if.dmem_wstrb = 4'd0;
        tick();
        quiet();
        cnt = 0;
        while (bus_if.memory_valid === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        check_eq("to_len", 128'(cnt), 128'd8);
        check_eq("to_resp", 128'({bus_if.dmem_ready, bus_if.dmem_error, bus_if.dmem_rdata}),
                            128'({1'b1, 1'b1, 32'd0}));
        tick();

        // Memory answers in the expiry cycle: normal completion.
        bus_if.dmem_valid = 1'b1; bus_if.dmem_addr = 32'h0000_0704;
        tick();
        quiet();
        for (int k = 0; k < 7; k++) tick();
        bus_if.memory_ready = 1'b1; bus_if.memory_rdata = 32'hA5A5_0001;
        tick();
        quiet();
        check_eq("to_edge", 128'({bus_if.dmem_ready, bus_if.dmem_error, bus_if.dmem_rdata}),
                            128'({1'b1, 1'b0, 32'hA5A5_0001}));
        tick();

        // Duplicate dmem pulse while in flight.
        d0 = obs_dresp;
        bus_if.dmem_valid = 1'b1; bus_if.dmem_addr = 32'h0000_0800; bus_if.dmem_wstrb = 4'h3;
        tick();
        quiet();
        bus_if.dmem_valid = 1'b1; bus_if.dmem_addr = 32'h0000_0900;
        tick();
        quiet();
        tick();
        bus_if.memory_ready = 1'b1;
        tick();
        quiet();
        for (int k = 0; k < 3; k++) tick();
        check_eq("dup_resp", 128'(obs_dresp - d0), 128'd1);
        check_eq("dup_idle", 128'(bus_if.memory_valid), 128'd0);

        // Reset in the middle of a fetch, late ready, then a clean fetch.
        bus_if.imem_valid = 1'b1; bus_if.imem_addr = 32'h0000_0A00;
        tick();
        quiet();
        tick();
        reset = 1'b1;
        tick();
        check_eq("rst_mid", 128'(bus_if.memory_valid), 128'd0);
        reset = 1'b0;
        bus_if.memory_ready = 1'b1;
        tick();
        quiet();
        check_eq("rst_late", 128'({bus_if.imem_ready, bus_if.memory_valid}), 128'd0);
        bus_if.imem_valid = 1'b1; bus_if.imem_addr = 32'h0000_0B00;
        tick();
        quiet();
        bus_if.memory_ready = 1'b1; bus_if.memory_rdata = 32'h0000_0011;
        tick();
        quiet();
        check_eq("rst_after", 128'({bus_if.imem_ready, bus_if.imem_rdata}), 128'({1'b1, 32'h0000_0011}));
        tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bus_if.imem_valid   = ($urandom_range(0, 3) == 0);
            bus_if.imem_addr    = $urandom;
            bus_if.dmem_valid   = ($urandom_range(0, 2) == 0);
            bus_if.dmem_addr    = $urandom;
            bus_if.dmem_wdata   = $urandom;
            bus_if.dmem_wstrb   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            bus_if.memory_ready = ($urandom_range(0, 9) < 4);
            bus_if.memory_rdata = $urandom;
            reset               = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        quiet();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
